// File: rtl/adder_accumulator.sv
// adder_accumulator_ripple
//   Ripple-carry adder used as the accumulator's sum datapath. At WIDTH=4 this
//   is the team's 4-bit ripple adder.
//   Ports: a, b  - addends; cin - carry in; sum - a+b+cin mod 2^WIDTH;
//          cout - carry out of the top bit.
//
// adder_accumulator
//   Accepts operands over a valid/ready handshake and accumulates COUNT of
//   them into a running sum. Then it presents the batch sum and a sticky
//   unsigned-overflow flag over an output valid/ready handshake.
//   Ports: clk, rst_n (async, active low);
//          in_valid/in_ready/in_data  - operand stream;
//          out_valid/out_ready        - result handshake;
//          out_sum                    - batch sum mod 2^WIDTH;
//          out_ovf                    - at least one carry-out in the batch.

module adder_accumulator_ripple #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   // The carry is a loop-local variable that walks up the bits, so that the
   // chain stays a single combinational path.
   always_comb begin
      logic c;
      c    = cin;
      sum  = '0;
      for (int i = 0; i < WIDTH; i++) begin
         sum[i] = a[i] ^ b[i] ^ c;
         c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
      end
      cout = c;
   end

endmodule

module adder_accumulator #(
   parameter int WIDTH = 4,
   parameter int COUNT = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_ovf
);

   localparam int CNT_W = $clog2(COUNT + 1);

   localparam logic [0:0] ST_ACC  = 1'b0;
   localparam logic [0:0] ST_DONE = 1'b1;

   logic [0:0]       state;
   logic [WIDTH-1:0] acc;
   logic [CNT_W-1:0] cnt;
   logic             ovf;

   logic [WIDTH-1:0] sum;
   logic             carry;
   logic             accept;
   logic             last;

   // The carry-out of the adder equals (sum < acc) for an unsigned add.
   adder_accumulator_ripple #(.WIDTH(WIDTH)) u_add (
      .a    (acc),
      .b    (in_data),
      .cin  (1'b0),
      .sum  (sum),
      .cout (carry)
   );

   // Both handshake outputs are decoded from registered state only.
   assign in_ready  = (state == ST_ACC);
   assign out_valid = (state == ST_DONE);
   assign out_sum   = acc;
   assign out_ovf   = ovf;

   assign accept = in_valid && in_ready;
   assign last   = (cnt == CNT_W'(COUNT - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_ACC;
         acc   <= '0;
         cnt   <= '0;
         ovf   <= 1'b0;
      end else begin
         case (state)
            ST_ACC: begin
               if (accept) begin
                  acc <= sum;
                  ovf <= ovf | carry;
                  if (last) begin
                     cnt   <= '0;
                     state <= ST_DONE;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end
            ST_DONE: begin
               // No bypass into ST_ACC on the same edge. This gives the
               // single bubble cycle per batch.
               if (out_ready) begin
                  acc   <= '0;
                  ovf   <= 1'b0;
                  state <= ST_ACC;
               end
            end
            default: state <= ST_ACC;
         endcase
      end
   end

endmodule

// File: tb/tb_adder_accumulator.sv
// Self-checking bench for adder_accumulator (WIDTH=4, COUNT=4).
// The bench applies directed batches from a vector table and a hand-written
// mid-batch reset sequence. It then applies random batches and checks them
// against an arithmetic model: the sum is total mod 16, and the overflow flag
// is set when total >= 16.

module tb_adder_accumulator;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] in_data;
   logic       out_valid;
   logic       out_ready;
   logic [3:0] out_sum;
   logic       out_ovf;

   int checks   = 0;
   int failures = 0;

   adder_accumulator #(.WIDTH(4), .COUNT(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_ovf   (out_ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog expired got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [15:0] ops;    // operand i in bits [4i+3:4i]
      logic [15:0] gaps;   // idle cycles before operand i
      int          hold;   // cycles out_ready stays low while out_valid=1
      bit          poison; // drive in_valid=1, in_data=7 during the hold
      logic [3:0]  exp_sum;
      logic        exp_ovf;
      string       name;
   } vec_t;

   function automatic logic [15:0] pk(input int a, input int b, input int c, input int d);
      pk = {d[3:0], c[3:0], b[3:0], a[3:0]};
   endfunction

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
      end
   endtask

   task automatic run_batch(input vec_t v);
      int w;
      out_ready = (v.hold == 0);
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b0;
         for (int g = 0; g < int'(v.gaps[i*4 +: 4]); g++) begin
            @(posedge clk); #1;
            chk({v.name, " idle out_valid"}, 32'(out_valid), 32'd0);
         end
         in_valid = 1'b1;
         in_data  = v.ops[i*4 +: 4];
         w = 0;
         while (!in_ready && w < 20) begin
            @(posedge clk); #1;
            w++;
         end
         if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL %s in_ready wait got=0 exp=1", v.name);
         end
         @(posedge clk); #1;
         if (i < 3) chk({v.name, " early out_valid"}, 32'(out_valid), 32'd0);
      end
      in_valid = v.poison;
      in_data  = v.poison ? 4'd7 : 4'd0;
      chk({v.name, " out_valid"}, 32'(out_valid), 32'd1);
      chk({v.name, " in_ready done"}, 32'(in_ready), 32'd0);
      chk({v.name, " out_sum"}, 32'(out_sum), 32'(v.exp_sum));
      chk({v.name, " out_ovf"}, 32'(out_ovf), 32'(v.exp_ovf));
      for (int h = 0; h < v.hold; h++) begin
         @(posedge clk); #1;
         chk({v.name, " hold out_valid"}, 32'(out_valid), 32'd1);
         chk({v.name, " hold in_ready"}, 32'(in_ready), 32'd0);
         chk({v.name, " hold out_sum"}, 32'(out_sum), 32'(v.exp_sum));
         chk({v.name, " hold out_ovf"}, 32'(out_ovf), 32'(v.exp_ovf));
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk({v.name, " release out_valid"}, 32'(out_valid), 32'd0);
      chk({v.name, " release in_ready"}, 32'(in_ready), 32'd1);
      out_ready = 1'b0;
      in_valid  = 1'b0;
   endtask

   vec_t tbl [7];
   vec_t rv;
   vec_t v2;
   int   total;

   initial begin
      tbl[0] = '{pk(1,2,3,4),  pk(0,0,0,0), 0, 1'b0, 4'd10, 1'b0, "t1_seq"};
      tbl[1] = '{pk(15,1,0,0), pk(0,0,0,0), 0, 1'b0, 4'd0,  1'b1, "t2_wrap"};
      tbl[2] = '{pk(1,1,1,1),  pk(0,0,0,0), 0, 1'b0, 4'd4,  1'b0, "t2_clear"};
      tbl[3] = '{pk(2,2,2,2),  pk(0,0,0,0), 5, 1'b1, 4'd8,  1'b0, "t3_hold"};
      tbl[4] = '{pk(1,0,0,0),  pk(0,0,0,0), 0, 1'b0, 4'd1,  1'b0, "t3_after"};
      tbl[5] = '{pk(3,5,2,1),  pk(0,2,1,0), 0, 1'b0, 4'd11, 1'b0, "t4_sparse"};
      tbl[6] = '{pk(8,8,8,8),  pk(0,0,0,0), 0, 1'b0, 4'd0,  1'b1, "t6_two_carry"};

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = 4'd0;
      out_ready = 1'b0;
      #1;
      chk("reset out_valid", 32'(out_valid), 32'd0);
      chk("reset out_sum", 32'(out_sum), 32'd0);
      chk("reset out_ovf", 32'(out_ovf), 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      chk("reset in_ready", 32'(in_ready), 32'd1);

      foreach (tbl[i]) run_batch(tbl[i]);

      // Mid-batch asynchronous reset: 9+9 gives 2 with a carry, then everything clears.
      in_valid = 1'b1;
      in_data  = 4'd9;
      @(posedge clk); #1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("t5 partial out_sum", 32'(out_sum), 32'd2);
      chk("t5 partial out_ovf", 32'(out_ovf), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("t5 async out_sum", 32'(out_sum), 32'd0);
      chk("t5 async out_ovf", 32'(out_ovf), 32'd0);
      chk("t5 async out_valid", 32'(out_valid), 32'd0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      v2 = '{pk(2,2,2,2), pk(0,0,0,0), 0, 1'b0, 4'd8, 1'b0, "t5_after"};
      run_batch(v2);

      // Random batches against the arithmetic model.
      for (int n = 0; n < 30; n++) begin
         total = 0;
         for (int i = 0; i < 4; i++) begin
            int op;
            int gp;
            op = int'($urandom_range(0, 15));
            gp = int'($urandom_range(0, 2));
            rv.ops[i*4 +: 4]  = op[3:0];
            rv.gaps[i*4 +: 4] = gp[3:0];
            total += op;
         end
         rv.hold    = int'($urandom_range(0, 3));
         rv.poison  = 1'($urandom_range(0, 1));
         rv.exp_sum = 4'(total % 16);
         rv.exp_ovf = (total >= 16);
         rv.name    = $sformatf("rand%0d", n);
         run_batch(rv);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
